// File: rtl/bcd_scan_counter_if.sv
// Control and display bundle for bcd_scan_counter: count controls in, count and
// multiplexed seven-segment drive out.
interface bcd_scan_counter_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    en;
  logic                    up;
  logic                    clr;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_bcd;
  logic                    blank_lz;
  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic                    wrap;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output en, up, clr, load, load_bcd, blank_lz,
    input  count_bcd, wrap, seg, an
  );

  modport slave (
    input  en, up, clr, load, load_bcd, blank_lz,
    output count_bcd, wrap, seg, an
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with tick prescaler and a time-multiplexed
// active-low seven-segment driver with optional leading-zero blanking.
module bcd_scan_counter #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 1000000,
  parameter int SCAN_DIV   = 125000
) (
  input logic          clk,
  input logic          rst,
  bcd_scan_counter_if.slave bus
);
  localparam int CW = 4 * NUM_DIGITS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(NUM_DIGITS - 1);

  logic [TW-1:0] tick_cnt_reg;
  logic [SW-1:0] scan_cnt_reg;
  logic [PW-1:0] pos_reg;
  logic [CW-1:0] count_reg;
  logic          wrap_reg;
  logic          tick;

  logic [CW-1:0] load_clamped;
  logic [CW-1:0] step_bcd;
  logic          step_wrap;
  logic          carry;
  logic [3:0]    cur_d;
  logic [3:0]    new_d;

  logic [3:0]            disp_digit;
  logic                  zero_run;
  logic                  lz_blank;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign tick = (tick_cnt_reg == TICK_LAST);

  // The tick prescaler free-runs; only rst restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_clamp
      assign load_clamped[4*gi +: 4] =
        (bus.load_bcd[4*gi +: 4] > 4'd9) ? 4'd9 : bus.load_bcd[4*gi +: 4];
    end
  endgenerate

  // Ripple carry/borrow digit by digit; a carry out of the top digit is the wrap.
  always_comb begin
    carry    = 1'b1;
    step_bcd = count_reg;
    cur_d    = 4'd0;
    new_d    = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur_d = count_reg[4*i +: 4];
      new_d = cur_d;
      if (carry) begin
        if (bus.up) begin
          if (cur_d == 4'd9) begin
            new_d = 4'd0;
          end else begin
            new_d = cur_d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (cur_d == 4'd0) begin
            new_d = 4'd9;
          end else begin
            new_d = cur_d - 4'd1;
            carry = 1'b0;
          end
        end
      end
      step_bcd[4*i +: 4] = new_d;
    end
    step_wrap = carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      if (bus.clr) begin
        count_reg <= '0;
      end else if (bus.load) begin
        count_reg <= load_clamped;
      end else if (tick && bus.en) begin
        count_reg <= step_bcd;
        wrap_reg  <= step_wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_reg <= '0;
      pos_reg      <= '0;
    end else if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_reg <= '0;
      pos_reg      <= (pos_reg == POS_LAST) ? '0 : pos_reg + PW'(1);
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SW'(1);
    end
  end

  // zero_run accumulates from the top digit down, so at position i it tells
  // whether digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    disp_digit = 4'd0;
    zero_run   = 1'b1;
    lz_blank   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (count_reg[4*i +: 4] == 4'd0);
      if (pos_reg == PW'(i)) begin
        disp_digit = count_reg[4*i +: 4];
        lz_blank   = bus.blank_lz && (i != 0) && zero_run;
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_next[i] = !((pos_reg == PW'(i)) && !lz_blank);
    end
    seg_next = lz_blank ? 7'b1111111 : seg_decode(disp_digit);
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_next[i] = (i != 0);
      end
      seg_next = 7'b1000000;
    end
  end

  assign bus.count_bcd = count_reg;
  assign bus.wrap      = wrap_reg;
  assign bus.an        = an_next;
  assign bus.seg       = seg_next;
endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of BCD digits and display positions; legal range 1..8.
REQ-002 SHALL have parameter TICK_DIV, default 1000000: clocks per count tick (10 ms at 100 MHz); legal range ≥1.
REQ-003 SHALL have parameter SCAN_DIV, default 125000: clocks per display position advance; legal range ≥1.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1: 1 = count on tick; 0 = hold value.
REQ-007 SHALL have port up, input, 1: 1 = increment; 0 = decrement.
REQ-008 SHALL have port clr, input, 1: synchronous clear of count to zero.
REQ-009 SHALL have port load, input, 1: synchronous load of load_bcd into count.
REQ-010 SHALL have port load_bcd, input, 4*NUM_DIGITS: packed BCD value; digit 0 in bits [3:0].
REQ-011 SHALL have port blank_lz, input, 1: 1 = suppress leading zeros on the display.
REQ-012 SHALL have port count_bcd, output, 4*NUM_DIGITS: current count, packed BCD, registered.
REQ-013 SHALL have port wrap, output, 1: one-cycle pulse on modulo wrap.
REQ-014 SHALL have port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-015 SHALL have port an, output, NUM_DIGITS: position select, active-low, one-hot-low; an[0] = least significant digit.

Function
REQ-016 SHALL run a tick prescaler that counts 0..TICK_DIV-1 continuously, independent of en.
REQ-017 SHALL assert an internal tick for one cycle when the tick prescaler equals TICK_DIV-1, then restart the prescaler at 0.
REQ-018 SHALL step the count on a cycle where tick=1 and en=1; count_bcd SHALL show the new value on the following cycle.
REQ-019 SHALL perform steps in per-digit BCD: on increment, a digit at 9 becomes 0 and carries to the next digit; on decrement, a digit at 0 becomes 9 and borrows from the next digit; no binary-to-decimal division.
REQ-020 SHALL count modulo 10^NUM_DIGITS; up from all-9s SHALL give all-0s, down from all-0s SHALL give all-9s.
REQ-021 SHALL assert wrap for exactly the cycle the wrapped value first appears on count_bcd; wrap SHALL be 0 otherwise.
REQ-022 SHALL apply control priority rst > clr > load > step; a step coincident with clr or load SHALL be discarded and wrap SHALL stay 0.
REQ-023 SHALL clamp any load_bcd nibble greater than 9 to 9 on load.
REQ-024 SHALL leave the tick prescaler running through clr and load; neither SHALL reset it.
REQ-025 SHALL run a scan prescaler that counts 0..SCAN_DIV-1 and advances a position index when it reaches SCAN_DIV-1.
REQ-026 SHALL advance the position index 0,1,..,NUM_DIGITS-1 and then back to 0, correct for counts that are not a power of two.
REQ-027 SHALL drive an low only at the bit of the current position index and seg with the decoded digit at that index.
REQ-028 SHALL decode digits as follows: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-029 SHALL, when blank_lz=1, blank position i>0 if digits i..NUM_DIGITS-1 are all zero: an all ones and seg=1111111 during that slot.
REQ-030 SHALL never blank position 0, so a count of zero displays a single "0".
REQ-031 SHALL, when NUM_DIGITS=1, hold the position index at 0 permanently.

Reset
REQ-032 SHALL, on a cycle with rst=1, clear count_bcd, both prescalers and the position index to 0 and clear wrap.
REQ-033 SHALL, during reset, drive an with bit 0 low and all other bits high, and seg=1000000.
REQ-034 SHALL, if rst is asserted mid-operation, discard any coincident tick, load or clr; the first tick SHALL come TICK_DIV cycles after rst deasserts.

Verification (NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=2 unless stated)
REQ-035 SHALL cover up-count carry: load 0x0099, en=1, up=1 -> after next tick count_bcd=0x0100; after a further tick count_bcd=0x0101.
REQ-036 SHALL cover both wraps: load 0x9999, up=1, one tick -> count_bcd=0x0000 with wrap=1 for 1 cycle; then up=0, one tick -> count_bcd=0x9999 with wrap=1.
REQ-037 SHALL cover priority: clr, load=0x1234 and tick in the same cycle -> count_bcd=0x0000, wrap=0; load=0x1234 with tick and no clr -> count_bcd=0x1234, not 0x1235.
REQ-038 SHALL cover clamping: load 0xA3F2 -> count_bcd=0x9392.
REQ-039 SHALL cover scan order with NUM_DIGITS=3: an sequence is 110,101,011,110, each held 2 cycles; load 0x0007 with blank_lz=1 -> slots 1 and 2 show an=111 and seg=1111111, slot 0 shows seg=1111000.
REQ-040 SHALL cover reset mid-count: count 0x0042, rst for 1 cycle coincident with tick -> count_bcd=0x0000, wrap=0, an=1110; next step occurs exactly 4 cycles after rst deasserts.
